// File: rtl/scope_window_stats_pkg.sv
// ============================================================================
// scope_meas_pkg : shared types and helpers for scope_window_stats
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package scope_meas_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACQ  = 1'b1
  } state_t;

  // Running-minimum seed: all-ones so any real sample compares lower.
  function automatic logic [63:0] min_seed(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scope_window_stats_chan_extrema.sv
// ============================================================================
// chan_extrema : per-channel running max/min and published max/min/pp
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module chan_extrema
  import scope_meas_pkg::*;
#(
  parameter int DATA_SIZE = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 seed,
  input  logic                 update,
  input  logic                 publish,
  input  logic                 include_sample,
  input  logic [DATA_SIZE-1:0] sample,
  output logic [DATA_SIZE-1:0] volt_max,
  output logic [DATA_SIZE-1:0] volt_min,
  output logic [DATA_SIZE-1:0] volt_pp
);

  localparam logic [DATA_SIZE-1:0] MIN_SEED = DATA_SIZE'(min_seed(DATA_SIZE));

  logic [DATA_SIZE-1:0] run_max;
  logic [DATA_SIZE-1:0] run_min;
  logic [DATA_SIZE-1:0] next_max;
  logic [DATA_SIZE-1:0] next_min;
  logic [DATA_SIZE-1:0] pub_max;
  logic [DATA_SIZE-1:0] pub_min;

  // A trigger publishes the window without its own sample; saturation includes it.
  always_comb begin
    next_max = (sample > run_max) ? sample : run_max;
    next_min = (sample < run_min) ? sample : run_min;
    pub_max  = include_sample ? next_max : run_max;
    pub_min  = include_sample ? next_min : run_min;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_max  <= '0;
      run_min  <= MIN_SEED;
      volt_max <= '0;
      volt_min <= '0;
      volt_pp  <= '0;
    end else begin
      if (seed) begin
        run_max <= sample;
        run_min <= sample;
      end else if (update) begin
        run_max <= next_max;
        run_min <= next_min;
      end
      if (publish) begin
        volt_max <= pub_max;
        volt_min <= pub_min;
        volt_pp  <= pub_max - pub_min;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/scope_window_stats.sv
// ============================================================================
// scope_window_stats : multi-channel trigger-window max/min/pp and period
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module scope_window_stats
  import scope_meas_pkg::*;
#(
  parameter int DATA_SIZE = 12,
  parameter int CH_NUM    = 2,
  parameter int PERIOD_W  = 20
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sample_valid_i,
  input  logic [CH_NUM*DATA_SIZE-1:0] sample_data_i,
  input  logic                        trigger_i,
  output logic [CH_NUM*DATA_SIZE-1:0] volt_max_o,
  output logic [CH_NUM*DATA_SIZE-1:0] volt_min_o,
  output logic [CH_NUM*DATA_SIZE-1:0] volt_pp_o,
  output logic [PERIOD_W-1:0]         period_o,
  output logic                        timeout_o,
  output logic                        result_valid_o
);

  localparam logic [PERIOD_W-1:0] PERIOD_MAX  = '1;
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = {{(PERIOD_W-1){1'b1}}, 1'b0};

  state_t              state;
  logic [PERIOD_W-1:0] count;
  logic                in_acq;
  logic                sat_hit;
  logic                seed;
  logic                update;
  logic                publish;

  // The next non-trigger sample would take the count to all-ones.
  always_comb begin
    in_acq  = (state == ACQ);
    sat_hit = (count == PERIOD_LAST);
    seed    = sample_valid_i && trigger_i;
    update  = sample_valid_i && !trigger_i && in_acq;
    publish = sample_valid_i && in_acq && (trigger_i || sat_hit);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      count          <= '0;
      period_o       <= '0;
      timeout_o      <= 1'b0;
      result_valid_o <= 1'b0;
    end else begin
      result_valid_o <= 1'b0;
      if (sample_valid_i) begin
        if (!in_acq) begin
          if (trigger_i) begin
            count <= PERIOD_W'(1);
            state <= ACQ;
          end
        end else if (trigger_i) begin
          period_o       <= count;
          timeout_o      <= 1'b0;
          result_valid_o <= 1'b1;
          count          <= PERIOD_W'(1);
        end else if (sat_hit) begin
          period_o       <= PERIOD_MAX;
          timeout_o      <= 1'b1;
          result_valid_o <= 1'b1;
          count          <= '0;
          state          <= IDLE;
        end else begin
          count <= count + PERIOD_W'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_chan
    chan_extrema #(
      .DATA_SIZE (DATA_SIZE)
    ) u_chan (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .seed           (seed),
      .update         (update),
      .publish        (publish),
      .include_sample (!trigger_i),
      .sample         (sample_data_i[c*DATA_SIZE +: DATA_SIZE]),
      .volt_max       (volt_max_o[c*DATA_SIZE +: DATA_SIZE]),
      .volt_min       (volt_min_o[c*DATA_SIZE +: DATA_SIZE]),
      .volt_pp        (volt_pp_o[c*DATA_SIZE +: DATA_SIZE])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_scope_window_stats.sv
// ============================================================================
// tb_scope_window_stats : directed self-checking bench for scope_window_stats
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scope_window_stats;

  localparam int DATA_SIZE = 12;
  localparam int CH_NUM    = 2;
  localparam int PERIOD_W  = 4;

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  logic                        sample_valid_i;
  logic                        trigger_i;
  logic [CH_NUM*DATA_SIZE-1:0] sample_data_i;
  logic [CH_NUM*DATA_SIZE-1:0] volt_max_o;
  logic [CH_NUM*DATA_SIZE-1:0] volt_min_o;
  logic [CH_NUM*DATA_SIZE-1:0] volt_pp_o;
  logic [PERIOD_W-1:0]         period_o;
  logic                        timeout_o;
  logic                        result_valid_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  scope_window_stats #(
    .DATA_SIZE (DATA_SIZE),
    .CH_NUM    (CH_NUM),
    .PERIOD_W  (PERIOD_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sample_valid_i (sample_valid_i),
    .sample_data_i  (sample_data_i),
    .trigger_i      (trigger_i),
    .volt_max_o     (volt_max_o),
    .volt_min_o     (volt_min_o),
    .volt_pp_o      (volt_pp_o),
    .period_o       (period_o),
    .timeout_o      (timeout_o),
    .result_valid_o (result_valid_o)
  );

  // Apply one cycle of input, then land 1 time unit after the capturing edge.
  task automatic step(input logic v, input logic t, input logic [11:0] d0, input logic [11:0] d1);
    sample_valid_i = v;
    trigger_i      = t;
    sample_data_i  = {d1, d0};
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(1'b0, 1'b0, 12'd0, 12'd0);
    step(1'b0, 1'b0, 12'd0, 12'd0);
    total_cnt++; if (volt_max_o !== 24'd0) $display("FAIL reset_max: got %h want 0", volt_max_o); else pass_cnt++;
    total_cnt++; if (volt_min_o !== 24'd0) $display("FAIL reset_min: got %h want 0", volt_min_o); else pass_cnt++;
    total_cnt++; if ({volt_pp_o, period_o, timeout_o, result_valid_o} !== 30'd0)
      $display("FAIL reset_misc: got pp=%h per=%0d to=%b rv=%b want all 0", volt_pp_o, period_o, timeout_o, result_valid_o);
    else pass_cnt++;
    rst_i = 1'b0;
  endtask

  task automatic test_basic_window();
    step(1'b1, 1'b1, 12'd100, 12'd50);
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL first_trigger_no_pulse: got rv=%b want 0", result_valid_o); else pass_cnt++;
    step(1'b1, 1'b0, 12'd300, 12'd60);
    step(1'b1, 1'b0, 12'd20, 12'd40);
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL basic_no_early_pulse: got rv=%b want 0", result_valid_o); else pass_cnt++;
    step(1'b1, 1'b1, 12'd5, 12'd5);
    total_cnt++; if (result_valid_o !== 1'b1) $display("FAIL basic_pulse: got rv=%b want 1", result_valid_o); else pass_cnt++;
    total_cnt++; if (volt_max_o !== {12'd60, 12'd300}) $display("FAIL basic_max: got %h want %h", volt_max_o, {12'd60, 12'd300}); else pass_cnt++;
    total_cnt++; if (volt_min_o !== {12'd40, 12'd20}) $display("FAIL basic_min: got %h want %h", volt_min_o, {12'd40, 12'd20}); else pass_cnt++;
    total_cnt++; if (volt_pp_o !== {12'd20, 12'd280}) $display("FAIL basic_pp: got %h want %h", volt_pp_o, {12'd20, 12'd280}); else pass_cnt++;
    total_cnt++; if ({period_o, timeout_o} !== {4'd3, 1'b0}) $display("FAIL basic_period: got per=%0d to=%b want per=3 to=0", period_o, timeout_o); else pass_cnt++;
    step(1'b0, 1'b0, 12'd0, 12'd0);
    total_cnt++; if ({result_valid_o, volt_max_o} !== {1'b0, 12'd60, 12'd300})
      $display("FAIL basic_hold: got rv=%b max=%h want rv=0 max=%h", result_valid_o, volt_max_o, {12'd60, 12'd300});
    else pass_cnt++;
  endtask

  task automatic test_invalid_gaps();
    // Window currently seeded with (5,5), count 1.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 12'd4095, 12'd4095);
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL gap_no_pulse: got rv=%b want 0", result_valid_o); else pass_cnt++;
    step(1'b1, 1'b0, 12'd8, 12'd9);
    step(1'b1, 1'b1, 12'd1, 12'd1);
    total_cnt++; if ({result_valid_o, period_o} !== {1'b1, 4'd2}) $display("FAIL gap_period: got rv=%b per=%0d want rv=1 per=2", result_valid_o, period_o); else pass_cnt++;
    total_cnt++; if (volt_max_o !== {12'd9, 12'd8}) $display("FAIL gap_max: got %h want %h", volt_max_o, {12'd9, 12'd8}); else pass_cnt++;
    total_cnt++; if (volt_min_o !== {12'd5, 12'd5}) $display("FAIL gap_min: got %h want %h", volt_min_o, {12'd5, 12'd5}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 12'd7, 12'd7);
    total_cnt++; if ({result_valid_o, period_o, volt_max_o} !== {1'b1, 4'd1, 12'd1, 12'd1})
      $display("FAIL b2b_first: got rv=%b per=%0d max=%h want rv=1 per=1 max=001001", result_valid_o, period_o, volt_max_o);
    else pass_cnt++;
    step(1'b1, 1'b1, 12'd9, 12'd9);
    total_cnt++; if ({result_valid_o, period_o} !== {1'b1, 4'd1}) $display("FAIL b2b_period: got rv=%b per=%0d want rv=1 per=1", result_valid_o, period_o); else pass_cnt++;
    total_cnt++; if ({volt_max_o, volt_min_o, volt_pp_o} !== {12'd7, 12'd7, 12'd7, 12'd7, 12'd0, 12'd0})
      $display("FAIL b2b_values: got max=%h min=%h pp=%h want max=007007 min=007007 pp=0", volt_max_o, volt_min_o, volt_pp_o);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    step(1'b1, 1'b1, 12'd10, 12'd10);
    for (int i = 1; i <= 13; i++) begin
      step(1'b1, 1'b0, 12'(20 + i), 12'(200 - i));
      if (result_valid_o !== 1'b0) early = 1'b1;
    end
    total_cnt++; if (early !== 1'b0) $display("FAIL timeout_early: got early pulse=%b want 0", early); else pass_cnt++;
    step(1'b1, 1'b0, 12'd34, 12'd186);
    total_cnt++; if ({result_valid_o, timeout_o, period_o} !== {1'b1, 1'b1, 4'hF})
      $display("FAIL timeout_flag: got rv=%b to=%b per=%0d want rv=1 to=1 per=15", result_valid_o, timeout_o, period_o);
    else pass_cnt++;
    total_cnt++; if ({volt_max_o, volt_min_o} !== {12'd199, 12'd34, 12'd10, 12'd10})
      $display("FAIL timeout_extrema: got max=%h min=%h want max=%h min=%h", volt_max_o, volt_min_o, {12'd199, 12'd34}, {12'd10, 12'd10});
    else pass_cnt++;
    total_cnt++; if (volt_pp_o !== {12'd189, 12'd24}) $display("FAIL timeout_pp: got %h want %h", volt_pp_o, {12'd189, 12'd24}); else pass_cnt++;
    step(1'b1, 1'b1, 12'd50, 12'd50);
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL timeout_rearm: got rv=%b want 0", result_valid_o); else pass_cnt++;
    step(1'b1, 1'b1, 12'd60, 12'd60);
    total_cnt++; if ({result_valid_o, timeout_o, period_o, volt_max_o} !== {1'b1, 1'b0, 4'd1, 12'd50, 12'd50})
      $display("FAIL timeout_next: got rv=%b to=%b per=%0d max=%h want rv=1 to=0 per=1 max=032032", result_valid_o, timeout_o, period_o, volt_max_o);
    else pass_cnt++;
  endtask

  task automatic test_trigger_at_saturation();
    // Window seeded with (60,60), count 1; 13 samples bring count to 14.
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 12'd70, 12'd70);
    step(1'b1, 1'b1, 12'd80, 12'd80);
    total_cnt++; if ({result_valid_o, timeout_o, period_o} !== {1'b1, 1'b0, 4'd14})
      $display("FAIL sat_trigger: got rv=%b to=%b per=%0d want rv=1 to=0 per=14", result_valid_o, timeout_o, period_o);
    else pass_cnt++;
    total_cnt++; if ({volt_max_o, volt_min_o} !== {12'd70, 12'd70, 12'd60, 12'd60})
      $display("FAIL sat_extrema: got max=%h min=%h want max=046046 min=03c03c", volt_max_o, volt_min_o);
    else pass_cnt++;
    step(1'b1, 1'b0, 12'd81, 12'd81);
    step(1'b1, 1'b1, 12'd0, 12'd0);
    total_cnt++; if ({result_valid_o, period_o, volt_max_o, volt_min_o} !== {1'b1, 4'd2, 12'd81, 12'd81, 12'd80, 12'd80})
      $display("FAIL sat_reseed: got rv=%b per=%0d max=%h min=%h want rv=1 per=2 max=051051 min=050050", result_valid_o, period_o, volt_max_o, volt_min_o);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 12'd40, 12'd40);
    #2;
    rst_i = 1'b1;
    #1;
    total_cnt++; if ({volt_max_o, volt_min_o, volt_pp_o, period_o, timeout_o, result_valid_o} !== 78'd0)
      $display("FAIL async_reset: got max=%h min=%h pp=%h per=%0d want all 0", volt_max_o, volt_min_o, volt_pp_o, period_o);
    else pass_cnt++;
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1'b1, 1'b1, 12'd3, 12'd3);
    total_cnt++; if (result_valid_o !== 1'b0) $display("FAIL reset_arm_only: got rv=%b want 0", result_valid_o); else pass_cnt++;
    step(1'b1, 1'b0, 12'd4, 12'd4);
    step(1'b1, 1'b1, 12'd0, 12'd0);
    total_cnt++; if ({result_valid_o, period_o, volt_max_o, volt_pp_o} !== {1'b1, 4'd2, 12'd4, 12'd4, 12'd1, 12'd1})
      $display("FAIL reset_next_window: got rv=%b per=%0d max=%h pp=%h want rv=1 per=2 max=004004 pp=001001", result_valid_o, period_o, volt_max_o, volt_pp_o);
    else pass_cnt++;
  endtask

  initial begin
    rst_i          = 1'b1;
    sample_valid_i = 1'b0;
    trigger_i      = 1'b0;
    sample_data_i  = '0;
    test_reset();
    test_basic_window();
    test_invalid_gaps();
    test_back_to_back();
    test_timeout();
    test_trigger_at_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
